// File: rtl/cfg_bitstream_loader.sv
// cfg_bitstream_loader
// Streams WORD_W-bit configuration words, LSB first, into a CHAIN_LEN-bit
// serial configuration chain. Bits of the final word that fall beyond the
// chain length are dropped. cfg_bit and cfg_shift_en come straight from flops
// so the chain clock-gate enable cannot glitch.
// Define CFG_LOADER_PARITY_EN to add the cfg_parity output (XOR of all bits
// shifted during the current load).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | word_ready high, waiting for the next word
// SHIFT | presenting one bit per cycle with cfg_shift_en high
// DONE  | one-cycle done pulse, then back to IDLE
module cfg_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_shift_en,
  output logic              busy,
  output logic              done
`ifdef CFG_LOADER_PARITY_EN
  ,
  output logic              cfg_parity
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WMAX_C = (WORD_W > CHAIN_LEN) ? LEN_C : CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [CNT_W-1:0]   word_bits_q;
  logic [CNT_W-1:0]   word_bits_d;
  // Holds the bits of the current word not yet presented on cfg_bit.
  logic [WORD_W-1:0]  sreg_q;
  logic               word_ready_q;
  logic               cfg_bit_q;
  logic               cfg_shift_en_q;
  logic               busy_q;
  logic               done_q;

  // Bits to take from a newly accepted word: the last word may be partial.
  assign word_bits_d = (remaining_q < WMAX_C) ? remaining_q : WMAX_C;

  // Sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge Config_Clock or negedge Config_Reset_n) begin
    if (!Config_Reset_n) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      word_bits_q    <= '0;
      sreg_q         <= '0;
      word_ready_q   <= 1'b0;
      cfg_bit_q      <= 1'b0;
      cfg_shift_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q        <= S_IDLE;
      word_ready_q   <= 1'b0;
      cfg_bit_q      <= 1'b0;
      cfg_shift_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_LOAD;
            remaining_q  <= LEN_C;
            word_bits_q  <= '0;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            state_q        <= S_SHIFT;
            sreg_q         <= word_data >> 1;
            cfg_bit_q      <= word_data[0];
            word_bits_q    <= word_bits_d;
            word_ready_q   <= 1'b0;
            cfg_shift_en_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          sreg_q <= sreg_q >> 1;
          if (word_bits_q != '0) word_bits_q <= word_bits_q - ONE_C;
          if (remaining_q != '0) remaining_q <= remaining_q - ONE_C;
          if (word_bits_q <= ONE_C) begin
            cfg_shift_en_q <= 1'b0;
            cfg_bit_q      <= 1'b0;
            if (remaining_q <= ONE_C) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_LOAD;
              word_ready_q <= 1'b1;
            end
          end else begin
            cfg_bit_q <= sreg_q[0];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign word_ready   = word_ready_q;
  assign cfg_bit      = cfg_bit_q;
  assign cfg_shift_en = cfg_shift_en_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef CFG_LOADER_PARITY_EN
  logic parity_q;

  // Running XOR of every bit presented to the chain during the current load.
  always_ff @(posedge Config_Clock or negedge Config_Reset_n) begin
    if (!Config_Reset_n) begin
      parity_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      parity_q <= 1'b0;
    end else if (cfg_shift_en_q) begin
      parity_q <= parity_q ^ cfg_bit_q;
    end
  end

  assign cfg_parity = parity_q;
`endif

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Bench for cfg_bitstream_loader: a 64-bit and a 40-bit chain instance share
// stimulus; sel picks which one is started and observed. Expected serial bits
// are queued at each word handshake and popped on every enabled shift cycle.
module tb_cfg_bitstream_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] word_data;
  logic        word_valid;
  logic        sel;

  logic rdy64, bit64, en64, busy64, done64;
  logic rdy40, bit40, en40, busy40, done40;
  logic m_ready, m_bit, m_en, m_busy, m_done;
  logic start64, start40;

  int   n_cmp;
  int   n_bad;
  logic exp_q[$];

  assign start64 = start & ~sel;
  assign start40 = start & sel;

  assign m_ready = sel ? rdy40  : rdy64;
  assign m_bit   = sel ? bit40  : bit64;
  assign m_en    = sel ? en40   : en64;
  assign m_busy  = sel ? busy40 : busy64;
  assign m_done  = sel ? done40 : done64;

`ifdef CFG_LOADER_PARITY_EN
  logic par64, par40, m_par;
  assign m_par = sel ? par40 : par64;
`endif

  cfg_bitstream_loader #(.CHAIN_LEN(64), .WORD_W(32)) dut64 (
    .Config_Clock   (clk),
    .Config_Reset_n (rst_n),
    .start          (start64),
    .abort          (abort),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (rdy64),
    .cfg_bit        (bit64),
    .cfg_shift_en   (en64),
    .busy           (busy64),
    .done           (done64)
`ifdef CFG_LOADER_PARITY_EN
    ,
    .cfg_parity     (par64)
`endif
  );

  cfg_bitstream_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut40 (
    .Config_Clock   (clk),
    .Config_Reset_n (rst_n),
    .start          (start40),
    .abort          (abort),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (rdy40),
    .cfg_bit        (bit40),
    .cfg_shift_en   (en40),
    .busy           (busy40),
    .done           (done40)
`ifdef CFG_LOADER_PARITY_EN
    ,
    .cfg_parity     (par40)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, int'(m_ready), 0);
    chk({tag, "_bit"},   int'(m_bit),   0);
    chk({tag, "_en"},    int'(m_en),    0);
    chk({tag, "_busy"},  int'(m_busy),  0);
    chk({tag, "_done"},  int'(m_done),  0);
`ifdef CFG_LOADER_PARITY_EN
    chk({tag, "_par"},   int'(m_par),   0);
`endif
  endtask

  // One load on the selected instance. hold_n withholds word_valid while the
  // second word is requested; abort_at / rst_at interrupt on that shift cycle;
  // restart_at pulses start while busy; exp_done is the start-to-done latency.
  task automatic do_load(input logic [31:0] w0, input logic [31:0] w1,
                         input int hold_n, input int abort_at, input int rst_at,
                         input int restart_at, input int exp_done);
    logic [31:0] wl [2];
    logic [31:0] cur;
    int   len, rem, widx, en_cnt, hs_cnt, done_cyc, hold, n;
    logic exp_b, mpar;
    bit   stop;
    wl[0] = w0;
    wl[1] = w1;
    len = sel ? 40 : 64;
    rem = len; widx = 0; en_cnt = 0; hs_cnt = 0; done_cyc = -1;
    hold = hold_n; mpar = 1'b0; stop = 1'b0;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    word_valid = 1'b1;
    word_data = w0;
    for (int k = 1; k <= 300 && !stop; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (abort) begin
        abort = 1'b0;
        chk("abort_en",   int'(m_en),   0);
        chk("abort_busy", int'(m_busy), 0);
        chk("abort_done", int'(m_done), 0);
        stop = 1'b1;
      end else begin
        if (m_en) begin
          en_cnt++;
          exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : ~m_bit;
          chk("stream_bit", int'(m_bit), int'(exp_b));
          if (en_cnt == abort_at) abort = 1'b1;
          if (en_cnt == rst_at) begin
            #2 rst_n = 1'b0;
            #1 chk_all_zero("async_rst");
            @(negedge clk);
            rst_n = 1'b1;
            stop = 1'b1;
          end
        end else begin
          chk("idle_bit", int'(m_bit), 0);
        end
        if (!stop) begin
          if (m_done) begin
            done_cyc = k;
            stop = 1'b1;
          end else if (m_ready && widx == 1 && hold > 0) begin
            word_valid = 1'b0;
            hold--;
            chk("hold_ready", int'(m_ready), 1);
            chk("hold_en",    int'(m_en),    0);
          end else begin
            word_valid = 1'b1;
            word_data = (widx == 0) ? wl[0] : wl[1];
            if (m_ready && widx < 2) begin
              cur = wl[widx];
              n = (rem < 32) ? rem : 32;
              for (int i = 0; i < n; i++) begin
                exp_q.push_back(cur[i]);
                mpar = mpar ^ cur[i];
              end
              rem -= n;
              widx++;
              hs_cnt++;
            end
          end
        end
      end
    end
    if (abort_at == 0 && rst_at == 0) begin
      chk("done_cycle", done_cyc, exp_done);
      chk("en_cycles",  en_cnt,   len);
      chk("handshakes", hs_cnt,   2);
      chk("queue_left", exp_q.size(), 0);
`ifdef CFG_LOADER_PARITY_EN
      chk("parity_done", int'(m_par), int'(mpar));
`endif
      @(negedge clk);
      chk("done_width", int'(m_done), 0);
      chk("busy_after", int'(m_busy), 0);
`ifdef CFG_LOADER_PARITY_EN
      chk("parity_hold", int'(m_par), int'(mpar));
`endif
    end else begin
      repeat (8) begin
        @(negedge clk);
        chk("no_done", int'(m_done), 0);
        chk("no_busy", int'(m_busy), 0);
        chk("no_en",   int'(m_en),   0);
      end
    end
    word_valid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    word_data = '0;
    word_valid = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset64");
    sel = 1'b1;
    #1 chk_all_zero("reset40");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two full words into the 64-bit chain
    do_load(32'hA5A5A5A5, 32'h0000FFFF, 0, 0, 0, 0, 67);
    // 40-bit chain: upper 24 bits of the second word must never appear
    sel = 1'b1;
    do_load(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 43);
    sel = 1'b0;
    // Valid withheld for 10 cycles before the second word
    do_load(32'h00000003, 32'h12345678, 10, 0, 0, 0, 77);
    // Abort on the fifth shift cycle, then a full load
    do_load(32'hCAFEF00D, 32'h13579BDF, 0, 5, 0, 0, 0);
    do_load(32'hDEADBEEF, 32'h0F0F00FF, 0, 0, 0, 20, 67);
    // Reset mid-shift, then a full load
    do_load(32'h89ABCDEF, 32'h76543210, 0, 0, 10, 0, 0);
    do_load(32'h600DC0DE, 32'h80000001, 0, 0, 0, 0, 67);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
